// File: rtl/frame_bank_sched_pkg.sv
// rtl/frame_bank_sched_pkg.sv - shared types and constants for the triple-buffer frame scheduler
package frame_bank_sched_pkg;

    typedef logic [1:0] bank_idx_t;

    localparam int NUM_BANKS = 3;

    // Power-up ownership: reader scans bank 0, bank 1 is "latest", writer fills bank 2
    localparam bank_idx_t RST_W_BANK = 2'd2;
    localparam bank_idx_t RST_L_BANK = 2'd1;
    localparam bank_idx_t RST_R_BANK = 2'd0;

    typedef enum logic {
        WR_IDLE   = 1'b0,
        WR_ACTIVE = 1'b1
    } wr_state_t;

endpackage

// File: rtl/frame_bank_addr.sv
// rtl/frame_bank_addr.sv - bank index to frame base address
module frame_bank_addr
    import frame_bank_sched_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 24,
    parameter logic [ADDR_WIDTH-1:0] FRAME_BASE   = 24'h000000,
    parameter logic [ADDR_WIDTH-1:0] FRAME_STRIDE = 24'h040000
) (
    input  bank_idx_t             bank,
    output logic [ADDR_WIDTH-1:0] base_addr
);

    logic [ADDR_WIDTH-1:0] stride_x2;
    logic [ADDR_WIDTH-1:0] off_lo;
    logic [ADDR_WIDTH-1:0] off_hi;

    // Shift-and-add instead of a multiplier; only indices 0..2 ever occur
    always_comb begin
        stride_x2 = {FRAME_STRIDE[ADDR_WIDTH-2:0], 1'b0};
        off_lo    = bank[0] ? FRAME_STRIDE : '0;
        off_hi    = bank[1] ? stride_x2 : '0;
        base_addr = FRAME_BASE + off_lo + off_hi;
    end

endmodule

// File: rtl/frame_bank_sched.sv
// rtl/frame_bank_sched.sv - triple-buffer bank scheduler between camera writer and LCD reader
module frame_bank_sched
    import frame_bank_sched_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 24,
    parameter logic [ADDR_WIDTH-1:0] FRAME_BASE   = 24'h000000,
    parameter logic [ADDR_WIDTH-1:0] FRAME_STRIDE = 24'h040000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_frame_req,
    output logic                  wr_frame_ack,
    output logic [ADDR_WIDTH-1:0] wr_base_addr,
    input  logic                  wr_frame_done,
    input  logic                  rd_frame_req,
    output logic                  rd_frame_ack,
    output logic [ADDR_WIDTH-1:0] rd_base_addr,
    output logic                  frame_valid,
    output logic                  wr_active,
    output logic [15:0]           drop_cnt,
    output logic [15:0]           repeat_cnt,
    output logic                  done_err
);

    localparam logic [ADDR_WIDTH-1:0] RST_WR_ADDR = FRAME_BASE + {FRAME_STRIDE[ADDR_WIDTH-2:0], 1'b0};
    localparam logic [ADDR_WIDTH-1:0] RST_RD_ADDR = FRAME_BASE;

    wr_state_t             state_q, state_d;
    bank_idx_t             w_q, w_d, l_q, l_d, r_q, r_d;
    logic                  new_avail_q, new_avail_d;
    logic                  frame_valid_q, frame_valid_d;
    logic                  wr_ack_q, wr_ack_d, rd_ack_q, rd_ack_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
    logic [15:0]           drop_q, drop_d, repeat_q, repeat_d;
    logic                  done_err_q, done_err_d;

    logic                  wr_acc, rd_acc, commit;
    logic [ADDR_WIDTH-1:0] wr_addr_next, rd_addr_next;

    // Applied in order: writer commit, reader swap, writer grant
    always_comb begin
        state_d       = state_q;
        w_d           = w_q;
        l_d           = l_q;
        r_d           = r_q;
        new_avail_d   = new_avail_q;
        frame_valid_d = frame_valid_q;
        drop_d        = drop_q;
        repeat_d      = repeat_q;
        done_err_d    = done_err_q;

        wr_acc   = wr_frame_req & ~wr_ack_q;
        rd_acc   = rd_frame_req & ~rd_ack_q;
        commit   = (state_q == WR_ACTIVE) & wr_frame_done;
        wr_ack_d = wr_acc;
        rd_ack_d = rd_acc;

        if ((state_q == WR_IDLE) && wr_frame_done) begin
            done_err_d = 1'b1;
        end

        if (commit) begin
            l_d           = w_q;
            w_d           = l_q;
            new_avail_d   = 1'b1;
            frame_valid_d = 1'b1;
            state_d       = WR_IDLE;
            if (new_avail_q && (drop_q != 16'hFFFF)) begin
                drop_d = drop_q + 16'd1;
            end
        end

        if (rd_acc) begin
            if (new_avail_d) begin
                r_d         = l_d;
                l_d         = r_q;
                new_avail_d = 1'b0;
            end else if (frame_valid_q && (repeat_q != 16'hFFFF)) begin
                repeat_d = repeat_q + 16'd1;
            end
        end

        // An accept while ACTIVE without done is an abort: same W, re-acked
        if (wr_acc) begin
            state_d = WR_ACTIVE;
        end
    end

    frame_bank_addr #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .FRAME_BASE  (FRAME_BASE),
        .FRAME_STRIDE(FRAME_STRIDE)
    ) u_wr_addr (
        .bank     (w_d),
        .base_addr(wr_addr_next)
    );

    frame_bank_addr #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .FRAME_BASE  (FRAME_BASE),
        .FRAME_STRIDE(FRAME_STRIDE)
    ) u_rd_addr (
        .bank     (r_d),
        .base_addr(rd_addr_next)
    );

    always_comb begin
        wr_addr_d = wr_acc ? wr_addr_next : wr_addr_q;
        rd_addr_d = rd_acc ? rd_addr_next : rd_addr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= WR_IDLE;
            w_q           <= RST_W_BANK;
            l_q           <= RST_L_BANK;
            r_q           <= RST_R_BANK;
            new_avail_q   <= 1'b0;
            frame_valid_q <= 1'b0;
            wr_ack_q      <= 1'b0;
            rd_ack_q      <= 1'b0;
            wr_addr_q     <= RST_WR_ADDR;
            rd_addr_q     <= RST_RD_ADDR;
            drop_q        <= 16'd0;
            repeat_q      <= 16'd0;
            done_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            w_q           <= w_d;
            l_q           <= l_d;
            r_q           <= r_d;
            new_avail_q   <= new_avail_d;
            frame_valid_q <= frame_valid_d;
            wr_ack_q      <= wr_ack_d;
            rd_ack_q      <= rd_ack_d;
            wr_addr_q     <= wr_addr_d;
            rd_addr_q     <= rd_addr_d;
            drop_q        <= drop_d;
            repeat_q      <= repeat_d;
            done_err_q    <= done_err_d;
        end
    end

    assign wr_frame_ack = wr_ack_q;
    assign rd_frame_ack = rd_ack_q;
    assign wr_base_addr = wr_addr_q;
    assign rd_base_addr = rd_addr_q;
    assign frame_valid  = frame_valid_q;
    assign wr_active    = (state_q == WR_ACTIVE);
    assign drop_cnt     = drop_q;
    assign repeat_cnt   = repeat_q;
    assign done_err     = done_err_q;

endmodule

// File: tb/tb_frame_bank_sched.sv
// tb/tb_frame_bank_sched.sv - scoreboard bench for frame_bank_sched
module tb_frame_bank_sched;

    localparam logic [23:0] B0 = 24'h000000;
    localparam logic [23:0] B1 = 24'h040000;
    localparam logic [23:0] B2 = 24'h080000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_frame_req = 1'b0;
    logic        wr_frame_ack;
    logic [23:0] wr_base_addr;
    logic        wr_frame_done = 1'b0;
    logic        rd_frame_req = 1'b0;
    logic        rd_frame_ack;
    logic [23:0] rd_base_addr;
    logic        frame_valid;
    logic        wr_active;
    logic [15:0] drop_cnt;
    logic [15:0] repeat_cnt;
    logic        done_err;

    int checks = 0;
    int failures = 0;
    logic [23:0] wr_exp_q[$];
    logic [23:0] rd_exp_q[$];

    frame_bank_sched #(
        .ADDR_WIDTH  (24),
        .FRAME_BASE  (24'h000000),
        .FRAME_STRIDE(24'h040000)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_frame_req (wr_frame_req),
        .wr_frame_ack (wr_frame_ack),
        .wr_base_addr (wr_base_addr),
        .wr_frame_done(wr_frame_done),
        .rd_frame_req (rd_frame_req),
        .rd_frame_ack (rd_frame_ack),
        .rd_base_addr (rd_base_addr),
        .frame_valid  (frame_valid),
        .wr_active    (wr_active),
        .drop_cnt     (drop_cnt),
        .repeat_cnt   (repeat_cnt),
        .done_err     (done_err)
    );

    always #5 clk = ~clk;

    task automatic do_rd_req(input logic [23:0] exp);
        int n;
        logic [23:0] e;
        rd_exp_q.push_back(exp);
        @(negedge clk);
        rd_frame_req = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rd_frame_ack && n < 8);
        rd_frame_req = 1'b0;
        e = rd_exp_q.pop_front();
        checks++;
        if (rd_frame_ack !== 1'b1 || n !== 1) begin
            failures++;
            $display("FAIL rd_ack_latency: ack=%b cycles=%0d required ack=1 cycles=1", rd_frame_ack, n);
        end
        checks++;
        if (rd_base_addr !== e) begin
            failures++;
            $display("FAIL rd_base_addr: got %h required %h", rd_base_addr, e);
        end
        @(negedge clk);
        checks++;
        if (rd_frame_ack !== 1'b0) begin
            failures++;
            $display("FAIL rd_ack_width: ack=%b required 0", rd_frame_ack);
        end
    endtask

    task automatic do_wr_req(input logic [23:0] exp);
        int n;
        logic [23:0] e;
        wr_exp_q.push_back(exp);
        @(negedge clk);
        wr_frame_req = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!wr_frame_ack && n < 8);
        wr_frame_req = 1'b0;
        e = wr_exp_q.pop_front();
        checks++;
        if (wr_frame_ack !== 1'b1 || n !== 1) begin
            failures++;
            $display("FAIL wr_ack_latency: ack=%b cycles=%0d required ack=1 cycles=1", wr_frame_ack, n);
        end
        checks++;
        if (wr_base_addr !== e) begin
            failures++;
            $display("FAIL wr_base_addr: got %h required %h", wr_base_addr, e);
        end
        @(negedge clk);
        checks++;
        if (wr_frame_ack !== 1'b0) begin
            failures++;
            $display("FAIL wr_ack_width: ack=%b required 0", wr_frame_ack);
        end
    endtask

    task automatic pulse_done();
        @(negedge clk);
        wr_frame_done = 1'b1;
        @(negedge clk);
        wr_frame_done = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({wr_frame_ack, rd_frame_ack, frame_valid, wr_active, done_err} !== 5'b0 ||
            drop_cnt !== 16'd0 || repeat_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_flags: acks=%b%b fv=%b act=%b err=%b drop=%0d rep=%0d required all 0",
                     wr_frame_ack, rd_frame_ack, frame_valid, wr_active, done_err, drop_cnt, repeat_cnt);
        end
        checks++;
        if (wr_base_addr !== B2 || rd_base_addr !== B0) begin
            failures++;
            $display("FAIL reset_addr: wr=%h rd=%h required wr=%h rd=%h", wr_base_addr, rd_base_addr, B2, B0);
        end
        rst_n = 1'b1;
        do_rd_req(B0);
        checks++;
        if (frame_valid !== 1'b0 || repeat_cnt !== 16'd0) begin
            failures++;
            $display("FAIL first_read_state: fv=%b rep=%0d required fv=0 rep=0", frame_valid, repeat_cnt);
        end
    endtask

    task automatic test_commit();
        do_wr_req(B2);
        checks++;
        if (wr_active !== 1'b1) begin
            failures++;
            $display("FAIL wr_active_after_grant: got %b required 1", wr_active);
        end
        pulse_done();
        checks++;
        if (frame_valid !== 1'b1 || wr_active !== 1'b0) begin
            failures++;
            $display("FAIL commit_state: fv=%b act=%b required fv=1 act=0", frame_valid, wr_active);
        end
        do_rd_req(B2);
        do_rd_req(B2);
        checks++;
        if (repeat_cnt !== 16'd1) begin
            failures++;
            $display("FAIL repeat_cnt: got %0d required 1", repeat_cnt);
        end
    endtask

    task automatic test_drop();
        do_wr_req(B1);
        pulse_done();
        do_wr_req(B0);
        pulse_done();
        checks++;
        if (drop_cnt !== 16'd1) begin
            failures++;
            $display("FAIL drop_cnt: got %0d required 1", drop_cnt);
        end
        do_rd_req(B0);
        do_wr_req(B1);
        checks++;
        if (rd_base_addr === wr_base_addr) begin
            failures++;
            $display("FAIL drop_distinct: rd=%h wr=%h required different", rd_base_addr, wr_base_addr);
        end
    endtask

    task automatic test_same_cycle();
        logic [23:0] e;
        rd_exp_q.push_back(B1);
        @(negedge clk);
        wr_frame_done = 1'b1;
        rd_frame_req  = 1'b1;
        @(negedge clk);
        wr_frame_done = 1'b0;
        rd_frame_req  = 1'b0;
        e = rd_exp_q.pop_front();
        checks++;
        if (rd_frame_ack !== 1'b1 || rd_base_addr !== e) begin
            failures++;
            $display("FAIL same_cycle_rd: ack=%b addr=%h required ack=1 addr=%h", rd_frame_ack, rd_base_addr, e);
        end
        do_wr_req(B2);
        checks++;
        if (rd_base_addr === wr_base_addr || rd_base_addr !== B1 || drop_cnt !== 16'd1) begin
            failures++;
            $display("FAIL same_cycle_distinct: rd=%h wr=%h drop=%0d required rd=%h wr!=rd drop=1",
                     rd_base_addr, wr_base_addr, drop_cnt, B1);
        end
    endtask

    task automatic test_abort_and_done_err();
        do_wr_req(B2);
        checks++;
        if (frame_valid !== 1'b1 || drop_cnt !== 16'd1 || wr_active !== 1'b1 || done_err !== 1'b0) begin
            failures++;
            $display("FAIL abort_state: fv=%b drop=%0d act=%b err=%b required 1 1 1 0",
                     frame_valid, drop_cnt, wr_active, done_err);
        end
        pulse_done();
        checks++;
        if (wr_active !== 1'b0 || drop_cnt !== 16'd1 || done_err !== 1'b0) begin
            failures++;
            $display("FAIL abort_commit: act=%b drop=%0d err=%b required 0 1 0", wr_active, drop_cnt, done_err);
        end
        pulse_done();
        checks++;
        if (done_err !== 1'b1 || wr_active !== 1'b0) begin
            failures++;
            $display("FAIL done_err: err=%b act=%b required err=1 act=0", done_err, wr_active);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (done_err !== 1'b1) begin
            failures++;
            $display("FAIL done_err_sticky: got %b required 1", done_err);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [23:0] ew, er;
        do_wr_req(B0);
        checks++;
        if (wr_active !== 1'b1 || drop_cnt === 16'd0 || repeat_cnt === 16'd0) begin
            failures++;
            $display("FAIL pre_reset_state: act=%b drop=%0d rep=%0d required act=1 counters nonzero",
                     wr_active, drop_cnt, repeat_cnt);
        end
        @(negedge clk);
        #2;
        rst_n        = 1'b0;
        wr_frame_req = 1'b1;
        rd_frame_req = 1'b1;
        #1;
        checks++;
        if ({wr_frame_ack, rd_frame_ack, frame_valid, wr_active, done_err} !== 5'b0 ||
            drop_cnt !== 16'd0 || repeat_cnt !== 16'd0 || wr_base_addr !== B2 || rd_base_addr !== B0) begin
            failures++;
            $display("FAIL async_reset: acks=%b%b fv=%b act=%b err=%b drop=%0d rep=%0d wr=%h rd=%h required reset values",
                     wr_frame_ack, rd_frame_ack, frame_valid, wr_active, done_err, drop_cnt, repeat_cnt,
                     wr_base_addr, rd_base_addr);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (wr_frame_ack !== 1'b0 || rd_frame_ack !== 1'b0) begin
                failures++;
                $display("FAIL ack_in_reset: wr=%b rd=%b required 0", wr_frame_ack, rd_frame_ack);
            end
        end
        wr_exp_q.push_back(B2);
        rd_exp_q.push_back(B0);
        rst_n = 1'b1;
        @(negedge clk);
        ew = wr_exp_q.pop_front();
        er = rd_exp_q.pop_front();
        checks++;
        if (wr_frame_ack !== 1'b1 || rd_frame_ack !== 1'b1 || wr_base_addr !== ew || rd_base_addr !== er) begin
            failures++;
            $display("FAIL held_req_after_reset: ack=%b%b wr=%h rd=%h required ack=11 wr=%h rd=%h",
                     wr_frame_ack, rd_frame_ack, wr_base_addr, rd_base_addr, ew, er);
        end
        wr_frame_req = 1'b0;
        rd_frame_req = 1'b0;
        @(negedge clk);
        checks++;
        if (repeat_cnt !== 16'd0 || wr_active !== 1'b1 || frame_valid !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_state: rep=%0d act=%b fv=%b required 0 1 0", repeat_cnt, wr_active, frame_valid);
        end
    endtask

    initial begin
        test_reset();
        test_commit();
        test_drop();
        test_same_cycle();
        test_abort_and_done_err();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/frame_bank_sched.md
Name: frame_bank_sched

Overview:
- Triple-buffer scheduler between the camera frame writer (SDRAM write side) and the LCD frame reader (the read_req/read_req_ack side of the video timing/data path).
- Owns three frame banks, hands each requester a base address by req/ack handshake, and commits finished writer frames.
- The reader always gets the newest complete frame; otherwise it repeats its current frame.
- Sits in the SDRAM controller clock domain; all requests arrive already synchronized to clk.

Parameters:
ADDR_WIDTH, 24, width of frame base addresses
FRAME_BASE, 24'h000000, address of bank 0
FRAME_STRIDE, 24'h040000, address distance between consecutive banks

Ports:
clk  in  1  scheduler/SDRAM clock
rst_n  in  1  asynchronous active-low reset
wr_frame_req  in  1  writer wants a new frame buffer; held high until ack seen, dropped the cycle after ack
wr_frame_ack  out  1  one-cycle grant to writer
wr_base_addr  out  ADDR_WIDTH  writer bank base; stable from ack until next wr ack
wr_frame_done  in  1  one-cycle pulse: writer finished current frame
rd_frame_req  in  1  reader starts a new frame (issued on every vsync edge); same handshake as writer
rd_frame_ack  out  1  one-cycle grant to reader
rd_base_addr  out  ADDR_WIDTH  reader bank base; stable from ack until next rd ack
frame_valid  out  1  at least one frame committed since reset
wr_active  out  1  writer FSM in ACTIVE
drop_cnt  out  16  committed frames overwritten before being read, saturating
repeat_cnt  out  16  reader grants that re-used the old frame while frame_valid=1, saturating
done_err  out  1  sticky: wr_frame_done received while writer IDLE

Behaviour:
- Reset is the only asynchronous path; everything else is updated on the clk rising edge.
- State registers are bank indices W (writer/free), L (latest), R (reader) plus flag new_avail.
- Invariant: {W,L,R} is always a permutation of {0,1,2}.
- Reset values:
  - W=2, L=1, R=0, new_avail=0.
  - Writer FSM=IDLE.
  - Both acks 0, frame_valid 0, counters 0, done_err 0.
  - wr_base_addr = base(2), rd_base_addr = base(0).
- Address: base(b) = FRAME_BASE + b*FRAME_STRIDE, truncated to ADDR_WIDTH. Address outputs are registered and update on the same edge that raises ack.
- Request acceptance: req sampled 1 while own ack=0. Ack goes high the next cycle for exactly one cycle, so latency is 1 clk. A req still high during its ack cycle is not re-accepted.
- Writer FSM:
  - IDLE + accepted wr req -> ACTIVE, ack with base(W).
  - ACTIVE + wr_frame_done -> IDLE, commit: L<=W, W<=old L, new_avail<=1, frame_valid<=1. If new_avail was already 1, drop_cnt++.
  - ACTIVE + accepted wr req without done -> abort: stay ACTIVE, no commit, re-ack the same base(W).
  - IDLE + wr_frame_done -> ignored, done_err<=1.
- Reader, on accepted rd req (no FSM; every req starts a frame):
  - If new_avail: swap R<->L, new_avail<=0.
  - Else: R unchanged; repeat_cnt++ if frame_valid.
  - Always ack with base of the resulting R.
- Same-cycle ordering: (1) writer commit, (2) reader swap, (3) writer grant. A reader request in the commit cycle therefore receives the just-committed frame, and a writer grant uses the post-update W.
- The reader never touches W. Writer commit never touches R, so the bank being scanned out is never overwritten.
- Counters saturate at 16'hFFFF.
- rst_n asserted mid-frame: immediate return to reset values. Requests held across reset deassertion are accepted normally, with ack 1 cycle after the first clk edge with rst_n high.

Decomposition:
- Shared package holds:
  - bank index typedef (2 bits)
  - NUM_BANKS=3
  - reset bank constants (W=2, L=1, R=0)
  - writer FSM state encoding (IDLE, ACTIVE)
- One natural sub-module: frame_bank_addr, combinational bank index -> base address using FRAME_BASE/FRAME_STRIDE. Instantiate it twice.

Test Plan:
- Reset then rd req -> ack 1 cycle later, rd_base_addr=0x000000, frame_valid=0, repeat_cnt=0.
- wr req, then done, then rd req:
  - wr_base_addr=0x080000 (bank 2).
  - After done: frame_valid=1.
  - Reader ack gives 0x080000.
  - Next rd req repeats 0x080000, repeat_cnt=1.
- Two writer frames committed with no read between -> drop_cnt=1. The next rd req gets the second frame's bank, and it differs from wr_base_addr.
- wr_frame_done and rd_frame_req accepted in the same cycle -> reader gets the just-committed bank. A wr req next cycle gets the remaining third bank, so all three bases are distinct.
- wr req while ACTIVE (abort) -> same wr_base_addr re-acked, no commit, frame_valid and drop_cnt unchanged. wr_frame_done while IDLE -> done_err=1.
- rst_n pulsed low while writer ACTIVE and counters nonzero -> all outputs return to reset values asynchronously. Ack is never asserted during reset.
